// File: rtl/ram_pkg.sv
// Shared types for the dual-port RAM and its clear sequencer.
package ram_pkg;

   typedef enum logic {
      CLEARING = 1'b0,
      IDLE     = 1'b1
   } ram_state_t;

endpackage

// File: rtl/ram_clear_sequencer.sv
// Sweeps every word address once after reset or on request, holding ready low meanwhile.
module ram_clear_sequencer
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  clear,
   output logic                  ready,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output ram_state_t            state_dbg
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   ram_state_t            r_state;
   ram_state_t            w_state_next;
   logic [ADDR_WIDTH-1:0] r_clr_addr;
   logic [ADDR_WIDTH-1:0] w_clr_addr_next;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= CLEARING;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_next;
         r_clr_addr <= w_clr_addr_next;
      end
   end

   // The counter parks at the last address rather than wrapping; only a clear request rewinds it.
   always_comb begin
      w_state_next    = r_state;
      w_clr_addr_next = r_clr_addr;
      case (r_state)
         CLEARING: begin
            if (r_clr_addr == LAST_ADDR) begin
               w_state_next = IDLE;
            end else begin
               w_clr_addr_next = r_clr_addr + ADDR_WIDTH'(1);
            end
         end
         IDLE: begin
            if (clear) begin
               w_state_next    = CLEARING;
               w_clr_addr_next = '0;
            end
         end
         default: begin
            w_state_next    = CLEARING;
            w_clr_addr_next = '0;
         end
      endcase
   end

   // Zero writes only happen on edges where the sequencer is out of reset.
   always_comb begin
      ready     = (r_state == IDLE);
      clr_we    = (r_state == CLEARING) && reset_n;
      clr_addr  = r_clr_addr;
      state_dbg = r_state;
   end

endmodule

// File: rtl/ram_dual_port.sv
// Dual-port RAM: port A read/write, port B read-only, both asynchronous read, with a zeroing sweep.
module ram_dual_port
   import ram_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [ADDR_WIDTH-1:0] addr_a,
   input  logic                  load_a,
   output logic [WIDTH-1:0]      out_a,
   input  logic [ADDR_WIDTH-1:0] addr_b,
   output logic [WIDTH-1:0]      out_b,
   input  logic                  clear,
   output logic                  ready
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [WIDTH-1:0]      mem [DEPTH];

   logic                  w_ready;
   logic                  w_clr_we;
   logic [ADDR_WIDTH-1:0] w_clr_addr;
   ram_state_t            w_state;
   logic                  w_we_a;

   ram_clear_sequencer #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_seq (
      .clock     (clock),
      .reset_n   (reset_n),
      .clear     (clear),
      .ready     (w_ready),
      .clr_we    (w_clr_we),
      .clr_addr  (w_clr_addr),
      .state_dbg (w_state)
   );

   // A clear request on the same edge as a load wins: the load is dropped.
   assign w_we_a = (w_state == IDLE) && load_a && !clear;

   always_ff @(posedge clock) begin
      if (w_clr_we) begin
         mem[w_clr_addr] <= '0;
      end else if (w_we_a) begin
         mem[addr_a] <= in_a;
      end
   end

   assign out_a = w_ready ? mem[addr_a] : '0;
   assign out_b = w_ready ? mem[addr_b] : '0;
   assign ready = w_ready;

endmodule

// File: tb/tb_ram_dual_port.sv
// Bench for ram_dual_port: a 16-word instance for the directed/random scenarios and a default-size one.
module tb_ram_dual_port;

   localparam int SA = 4;
   localparam int SD = 16;
   localparam int DA = 14;
   localparam int DD = 16384;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          s_reset_n;
   logic [15:0]   s_in_a;
   logic [SA-1:0] s_addr_a;
   logic          s_load_a;
   logic [15:0]   s_out_a;
   logic [SA-1:0] s_addr_b;
   logic [15:0]   s_out_b;
   logic          s_clear;
   logic          s_ready;

   logic          d_reset_n;
   logic [15:0]   d_in_a;
   logic [DA-1:0] d_addr_a;
   logic          d_load_a;
   logic [15:0]   d_out_a;
   logic [DA-1:0] d_addr_b;
   logic [15:0]   d_out_b;
   logic          d_clear;
   logic          d_ready;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] s_model [SD];
   logic [15:0] d_model [int];

   ram_dual_port #(.WIDTH(16), .ADDR_WIDTH(SA)) u_small (
      .clock   (clock),
      .reset_n (s_reset_n),
      .in_a    (s_in_a),
      .addr_a  (s_addr_a),
      .load_a  (s_load_a),
      .out_a   (s_out_a),
      .addr_b  (s_addr_b),
      .out_b   (s_out_b),
      .clear   (s_clear),
      .ready   (s_ready)
   );

   ram_dual_port u_default (
      .clock   (clock),
      .reset_n (d_reset_n),
      .in_a    (d_in_a),
      .addr_a  (d_addr_a),
      .load_a  (d_load_a),
      .out_a   (d_out_a),
      .addr_b  (d_addr_b),
      .out_b   (d_out_b),
      .clear   (d_clear),
      .ready   (d_ready)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic zero_model();
      for (int i = 0; i < SD; i++) s_model[i] = 16'h0000;
   endtask

   task automatic random_fill();
      for (int i = 0; i < SD; i++) begin
         s_addr_a = SA'(i);
         s_in_a   = 16'($urandom_range(1, 16'hFFFF));
         s_load_a = 1'b1;
         step();
         s_model[i] = s_in_a;
      end
      s_load_a = 1'b0;
   endtask

   task automatic test_reset();
      s_reset_n = 1'b0;
      #3;
      n_vec++;
      if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
      n_vec++;
      if (s_out_a !== 16'h0) begin n_err++; $display("FAIL reset_out_a got=%h exp=0000", s_out_a); end
      n_vec++;
      if (s_out_b !== 16'h0) begin n_err++; $display("FAIL reset_out_b got=%h exp=0000", s_out_b); end
      step();
      s_reset_n = 1'b1;
      for (int e = 1; e <= SD; e++) begin
         step();
         n_vec++;
         if (s_ready !== (e == SD)) begin
            n_err++; $display("FAIL sweep_ready edge=%0d got=%b exp=%b", e, s_ready, (e == SD));
         end
         if (e < SD) begin
            n_vec++;
            if (s_out_a !== 16'h0 || s_out_b !== 16'h0) begin
               n_err++; $display("FAIL sweep_outs edge=%0d got=%h/%h exp=0000/0000", e, s_out_a, s_out_b);
            end
         end
      end
      zero_model();
      for (int a = 0; a < SD; a++) begin
         s_addr_a = SA'(a);
         s_addr_b = SA'(SD - 1 - a);
         #1;
         n_vec++;
         if (s_out_a !== 16'h0 || s_out_b !== 16'h0) begin
            n_err++; $display("FAIL post_reset_zero addr=%0d got=%h/%h exp=0000/0000", a, s_out_a, s_out_b);
         end
      end
   endtask

   task automatic test_write_read();
      s_addr_a = 4'd3; s_in_a = 16'hBEEF; s_load_a = 1'b1;
      step();
      s_model[3] = 16'hBEEF;
      s_addr_a = 4'd9; s_in_a = 16'h1234;
      step();
      s_model[9] = 16'h1234;
      s_load_a = 1'b0;
      for (int a = 0; a < SD; a++) begin
         s_addr_b = SA'(a);
         #1;
         n_vec++;
         if (s_out_b !== s_model[a]) begin
            n_err++; $display("FAIL readback_b addr=%0d got=%h exp=%h", a, s_out_b, s_model[a]);
         end
      end
      s_addr_a = 4'd3; s_in_a = 16'h0F0F; s_load_a = 1'b1;
      step();
      s_model[3] = 16'h0F0F;
      s_load_a = 1'b0;
      s_addr_b = 4'd3;
      #1;
      n_vec++;
      if (s_out_a !== 16'h0F0F || s_out_b !== 16'h0F0F) begin
         n_err++; $display("FAIL rewrite_same_addr got=%h/%h exp=0f0f/0f0f", s_out_a, s_out_b);
      end
   endtask

   task automatic test_write_visibility();
      s_addr_a = 4'd5; s_addr_b = 4'd5; s_in_a = 16'hA5A5; s_load_a = 1'b1;
      #1;
      n_vec++;
      if (s_out_a !== s_model[5] || s_out_b !== s_model[5]) begin
         n_err++; $display("FAIL vis_before got=%h/%h exp=%h", s_out_a, s_out_b, s_model[5]);
      end
      step();
      s_model[5] = 16'hA5A5;
      s_load_a = 1'b0;
      n_vec++;
      if (s_out_a !== 16'hA5A5 || s_out_b !== 16'hA5A5) begin
         n_err++; $display("FAIL vis_after got=%h/%h exp=a5a5", s_out_a, s_out_b);
      end
   endtask

   task automatic test_clear_priority();
      s_addr_a = 4'd2; s_in_a = 16'h7777; s_load_a = 1'b1;
      step();
      s_model[2] = 16'h7777;
      s_in_a = 16'h1111; s_clear = 1'b1;
      step();
      s_clear = 1'b0; s_load_a = 1'b0;
      zero_model();
      n_vec++;
      if (s_ready !== 1'b0) begin n_err++; $display("FAIL clr_req_ready got=%b exp=0", s_ready); end
      for (int e = 1; e <= SD; e++) begin
         step();
         n_vec++;
         if (s_ready !== (e == SD)) begin
            n_err++; $display("FAIL clr_sweep_ready edge=%0d got=%b exp=%b", e, s_ready, (e == SD));
         end
      end
      s_addr_a = 4'd2; s_addr_b = 4'd2;
      #1;
      n_vec++;
      if (s_out_a !== 16'h0 || s_out_b !== 16'h0) begin
         n_err++; $display("FAIL clr_priority_addr2 got=%h/%h exp=0000", s_out_a, s_out_b);
      end
   endtask

   task automatic test_load_ignored();
      random_fill();
      s_clear = 1'b1;
      step();
      zero_model();
      for (int e = 1; e <= SD; e++) begin
         s_load_a = (e == 4);
         s_addr_a = 4'd1;
         s_in_a   = 16'hFFFF;
         step();
         n_vec++;
         if (s_ready !== (e == SD)) begin
            n_err++; $display("FAIL held_clear_ready edge=%0d got=%b exp=%b", e, s_ready, (e == SD));
         end
      end
      s_clear = 1'b0; s_load_a = 1'b0;
      for (int a = 0; a < SD; a++) begin
         s_addr_a = SA'(a); s_addr_b = SA'(a);
         #1;
         n_vec++;
         if (s_out_a !== s_model[a] || s_out_b !== s_model[a]) begin
            n_err++; $display("FAIL load_ignored_zero addr=%0d got=%h/%h exp=%h", a, s_out_a, s_out_b, s_model[a]);
         end
      end
   endtask

   task automatic test_mid_sweep_reset();
      random_fill();
      s_clear = 1'b1;
      step();
      s_clear = 1'b0;
      for (int e = 1; e <= 8; e++) step();
      s_reset_n = 1'b0;
      #1;
      n_vec++;
      if (s_ready !== 1'b0 || s_out_a !== 16'h0 || s_out_b !== 16'h0) begin
         n_err++; $display("FAIL mid_reset_async got ready=%b outs=%h/%h exp 0/0000/0000", s_ready, s_out_a, s_out_b);
      end
      for (int e = 0; e < 2; e++) begin
         step();
         n_vec++;
         if (s_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset_held_ready got=%b exp=0", s_ready); end
      end
      s_reset_n = 1'b1;
      zero_model();
      for (int e = 1; e <= SD; e++) begin
         step();
         n_vec++;
         if (s_ready !== (e == SD)) begin
            n_err++; $display("FAIL mid_reset_sweep edge=%0d got=%b exp=%b", e, s_ready, (e == SD));
         end
      end
      for (int a = 0; a < SD; a++) begin
         s_addr_b = SA'(a);
         #1;
         n_vec++;
         if (s_out_b !== 16'h0) begin
            n_err++; $display("FAIL mid_reset_zero addr=%0d got=%h exp=0000", a, s_out_b);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 200; i++) begin
         s_addr_a = SA'($urandom_range(0, SD - 1));
         s_addr_b = SA'($urandom_range(0, SD - 1));
         s_in_a   = 16'($urandom);
         s_load_a = 1'($urandom_range(0, 1));
         #1;
         n_vec++;
         if (s_out_a !== s_model[s_addr_a] || s_out_b !== s_model[s_addr_b]) begin
            n_err++; $display("FAIL b2b_pre it=%0d got=%h/%h exp=%h/%h", i, s_out_a, s_out_b,
                              s_model[s_addr_a], s_model[s_addr_b]);
         end
         step();
         if (s_load_a) s_model[s_addr_a] = s_in_a;
         n_vec++;
         if (s_out_a !== s_model[s_addr_a] || s_out_b !== s_model[s_addr_b]) begin
            n_err++; $display("FAIL b2b_post it=%0d got=%h/%h exp=%h/%h", i, s_out_a, s_out_b,
                              s_model[s_addr_a], s_model[s_addr_b]);
         end
      end
      s_load_a = 1'b0;
   endtask

   task automatic test_default_params();
      logic [DA-1:0] a;
      logic [DA-1:0] r;
      logic [15:0]   data;
      logic [15:0]   exp_r;
      d_reset_n = 1'b1;
      for (int e = 1; e <= DD; e++) begin
         step();
         if (e == 1 || e == DD - 1 || e == DD) begin
            n_vec++;
            if (d_ready !== (e == DD)) begin
               n_err++; $display("FAIL dflt_sweep edge=%0d got=%b exp=%b", e, d_ready, (e == DD));
            end
         end
      end
      for (int i = 0; i < 128; i++) begin
         a    = DA'($urandom_range(0, DD - 1));
         data = 16'($urandom);
         d_addr_a = a; d_in_a = data; d_load_a = 1'b1;
         step();
         d_load_a = 1'b0;
         d_model[int'(a)] = data;
         r = DA'($urandom_range(0, DD - 1));
         exp_r = d_model.exists(int'(r)) ? d_model[int'(r)] : 16'h0;
         d_addr_b = a; d_addr_a = r;
         #1;
         n_vec++;
         if (d_out_b !== data || d_out_a !== exp_r) begin
            n_err++; $display("FAIL dflt_readback it=%0d addr=%0d got=%h/%h exp=%h/%h", i, a, d_out_b, d_out_a, data, exp_r);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      s_reset_n = 1'b0; s_in_a = '0; s_addr_a = '0; s_load_a = 1'b0; s_addr_b = '0; s_clear = 1'b0;
      d_reset_n = 1'b0; d_in_a = '0; d_addr_a = '0; d_load_a = 1'b0; d_addr_b = '0; d_clear = 1'b0;
      test_reset();
      test_write_read();
      test_write_visibility();
      test_clear_priority();
      test_load_ignored();
      test_mid_sweep_reset();
      test_back_to_back();
      test_default_params();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
